// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the video receive path, the timing
// generator and the benches.
//   rx_state_e   : receiver lock FSM states
//   CRC16_*      : CRC-16-CCITT polynomial and seed for frame signatures
//   *_720P       : 1280x720p60 frame geometry
//   crc16_12()   : advance a CRC-16-CCITT by 12 data bits, MSB first
// ---------------------------------------------------------------------------
package video_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int H_TOTAL_720P  = 1650;
  localparam int H_ACTIVE_720P = 1280;
  localparam int V_TOTAL_720P  = 750;
  localparam int V_ACTIVE_720P = 720;

  // Bit-serial CRC unrolled over one 12-bit {r,g,b} word, MSB first
  function automatic logic [15:0] crc16_12(input logic [15:0] crc, input logic [11:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/video_rx_if.sv
// ---------------------------------------------------------------------------
// video_rx_if
// Parallel display-interface pins at pixel rate.
//   in_hsync / in_vsync : sync pulses (polarity set by the receiver)
//   in_de               : active-video enable
//   in_r / in_g / in_b  : 4-bit colour components
// Modports: master drives the pins (source / bench), slave receives them.
// ---------------------------------------------------------------------------
interface video_rx_if;
  logic       in_hsync;
  logic       in_vsync;
  logic       in_de;
  logic [3:0] in_r;
  logic [3:0] in_g;
  logic [3:0] in_b;

  modport master (output in_hsync, output in_vsync, output in_de,
                  output in_r, output in_g, output in_b);
  modport slave  (input in_hsync, input in_vsync, input in_de,
                  input in_r, input in_g, input in_b);
endinterface

// File: rtl/video_crc16.sv
// ---------------------------------------------------------------------------
// video_crc16
// Running CRC-16-CCITT over one 12-bit pixel per clock. Only built when
// VIDEO_RX_CRC_EN is defined.
//   pixel_clk, reset_n : clock, async active-low reset (CRC seeded)
//   i_clr              : restart from the seed; a pixel enabled in the same
//                        cycle is the first word of the new sequence
//   i_en, i_data       : pixel strobe and {r,g,b}
//   o_crc              : accumulated CRC
// ---------------------------------------------------------------------------
`ifdef VIDEO_RX_CRC_EN
module video_crc16
  import video_pkg::*;
(
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [11:0] i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_base;

  assign w_base = i_clr ? CRC16_INIT : r_crc;

  // CRC accumulator
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC16_INIT;
    end else if (i_en) begin
      r_crc <= crc16_12(w_base, i_data);
    end else begin
      r_crc <= w_base;
    end
  end

  assign o_crc = r_crc;

endmodule
`endif

// File: rtl/video_rx.sv
// ---------------------------------------------------------------------------
// video_rx
// Display-interface receiver: recovers active-pixel x/y, measures frame
// geometry and tracks lock.
// Pipeline: stage 1 registers pins and normalises sync polarity; stage 2
// does edge detection, counting and drives every output (2-clock latency).
// Ports:
//   pixel_clk, reset_n         : clock, async active-low reset
//   vin (video_rx_if.slave)    : hsync/vsync/de/rgb pins
//   pix_valid, x, y, pix_r/g/b : active pixel and its coordinates
//   frame_start                : one-cycle pulse on vsync leading edge
//   h_total/h_active/v_total/v_active : last completed frame geometry
//   locked                     : geometry stable
//   err                        : one-cycle pulse on loss of lock
// Optional feature (macro VIDEO_RX_CRC_EN): frame_crc / frame_crc_valid,
//   CRC-16-CCITT of every active pixel, published at frame start.
// Lock counting: the partial frame seen in SEARCH is discarded, the first
// full frame only becomes the reference, and each further matching frame
// bumps the match count, so lock needs LOCK_FRAMES+1 complete frames.
// ---------------------------------------------------------------------------
module video_rx
  import video_pkg::*;
#(
  parameter int COORD_W     = 16,
  parameter int LOCK_FRAMES = 2,
  parameter int HSYNC_POL   = 1,
  parameter int VSYNC_POL   = 1,
  parameter int TIMEOUT_W   = 16
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  video_rx_if.slave          vin,
  output logic               pix_valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [3:0]         pix_r,
  output logic [3:0]         pix_g,
  output logic [3:0]         pix_b,
  output logic               frame_start,
  output logic [COORD_W-1:0] h_total,
  output logic [COORD_W-1:0] h_active,
  output logic [COORD_W-1:0] v_total,
  output logic [COORD_W-1:0] v_active,
  output logic               locked,
  output logic               err
`ifdef VIDEO_RX_CRC_EN
  ,
  output logic [15:0]        frame_crc,
  output logic               frame_crc_valid
`endif
);

  localparam logic [3:0] C_LOCK = 4'(LOCK_FRAMES);

  function automatic logic [COORD_W-1:0] f_sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + {{(COORD_W-1){1'b0}}, 1'b1};
  endfunction

  logic w_hs_pin, w_vs_pin;
  logic r_hs1, r_vs1, r_de1, r_hs2, r_vs2, r_de2;
  logic [11:0] r_rgb1, r_pix_rgb;
  logic w_hs_rise, w_vs_rise, w_de_rise, w_de_fall, w_timeout, w_same;
  logic r_pix_valid, r_frame_start, r_locked, r_err;
  logic [COORD_W-1:0] r_x, r_y, r_hcnt, r_hacnt, r_h_meas, r_ha_meas, r_vcnt, r_vacnt;
  logic [COORD_W-1:0] r_h_total, r_h_active, r_v_total, r_v_active;
  logic [COORD_W-1:0] w_h_last, w_ha_last, w_v_last, w_va_last;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [3:0] r_match, w_match_nxt, w_match_inc;
  rx_state_e r_state, w_state_nxt;
  logic w_err_nxt, w_geo_load;

  // Normalise both syncs to active-high
  assign w_hs_pin = (HSYNC_POL != 0) ? vin.in_hsync : ~vin.in_hsync;
  assign w_vs_pin = (VSYNC_POL != 0) ? vin.in_vsync : ~vin.in_vsync;

  assign w_hs_rise = r_hs1 & ~r_hs2;
  assign w_vs_rise = r_vs1 & ~r_vs2;
  assign w_de_rise = r_de1 & ~r_de2;
  assign w_de_fall = ~r_de1 & r_de2;
  assign w_timeout = (&r_to_cnt) & ~w_hs_rise;

  // A line closing in the frame-start cycle belongs to the ending frame.
  // Blank lines carry no DE, so h_active keeps the last line that had any.
  assign w_h_last  = w_hs_rise ? r_hcnt : r_h_meas;
  assign w_ha_last = (w_hs_rise && (r_hacnt != '0)) ? r_hacnt : r_ha_meas;
  assign w_v_last  = w_hs_rise ? f_sat_inc(r_vcnt) : r_vcnt;
  assign w_va_last = w_de_fall ? f_sat_inc(r_vacnt) : r_vacnt;
  assign w_same    = (w_h_last == r_h_total) && (w_ha_last == r_h_active) &&
                     (w_v_last == r_v_total) && (w_va_last == r_v_active);
  assign w_match_inc = r_match + 4'd1;

  // Stage 1 input registers plus the delayed copies used for edge detection
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs1 <= 1'b0; r_vs1 <= 1'b0; r_de1 <= 1'b0; r_rgb1 <= 12'd0;
      r_hs2 <= 1'b0; r_vs2 <= 1'b0; r_de2 <= 1'b0;
    end else begin
      r_hs1 <= w_hs_pin; r_vs1 <= w_vs_pin; r_de1 <= vin.in_de;
      r_rgb1 <= {vin.in_r, vin.in_g, vin.in_b};
      r_hs2 <= r_hs1; r_vs2 <= r_vs1; r_de2 <= r_de1;
    end
  end

  // Stage 2 pixel outputs and active-pixel coordinates
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_valid <= 1'b0; r_pix_rgb <= 12'd0; r_frame_start <= 1'b0;
      r_x <= '0; r_y <= '0;
    end else begin
      r_pix_valid   <= r_de1;
      r_pix_rgb     <= r_rgb1;
      r_frame_start <= w_vs_rise;
      if (w_de_rise) r_x <= '0;
      else if (r_de1) r_x <= f_sat_inc(r_x);
      if (w_vs_rise) r_y <= '0;
      else if (w_de_fall) r_y <= f_sat_inc(r_y);
    end
  end

  // Line/frame measurement counters and the loss-of-signal timer
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt <= '0; r_hacnt <= '0; r_h_meas <= '0; r_ha_meas <= '0;
      r_vcnt <= '0; r_vacnt <= '0; r_to_cnt <= '0;
    end else begin
      if (w_hs_rise) begin
        r_hcnt   <= {{(COORD_W-1){1'b0}}, 1'b1};
        r_hacnt  <= {{(COORD_W-1){1'b0}}, r_de1};
        r_h_meas <= r_hcnt;
        if (r_hacnt != '0) r_ha_meas <= r_hacnt;
        r_to_cnt <= '0;
      end else begin
        r_hcnt <= f_sat_inc(r_hcnt);
        if (r_de1) r_hacnt <= f_sat_inc(r_hacnt);
        r_to_cnt <= r_to_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end
      if (w_vs_rise) begin
        r_vcnt <= '0; r_vacnt <= '0;
      end else begin
        if (w_hs_rise) r_vcnt <= f_sat_inc(r_vcnt);
        if (w_de_fall) r_vacnt <= f_sat_inc(r_vacnt);
      end
    end
  end

  // Lock FSM next-state, match count and error decision
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = 1'b0;
    w_geo_load  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = SEARCH;
      w_match_nxt = 4'd0;
      w_err_nxt   = (r_state == LOCKED);
    end else begin
      case (r_state)
        SEARCH: begin
          if (w_vs_rise) begin
            w_state_nxt = MEASURE;
            w_match_nxt = 4'd0;
          end else begin
            w_state_nxt = SEARCH;
          end
        end
        MEASURE: begin
          w_geo_load = w_vs_rise;
          if (w_vs_rise && w_same) begin
            w_match_nxt = w_match_inc;
            w_state_nxt = (w_match_inc == C_LOCK) ? LOCKED : MEASURE;
          end else if (w_vs_rise) begin
            w_match_nxt = 4'd0;
          end else begin
            w_state_nxt = MEASURE;
          end
        end
        LOCKED: begin
          w_geo_load = w_vs_rise;
          if ((w_vs_rise && !w_same) || (w_hs_rise && (r_hcnt != r_h_total))) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = MEASURE;
            w_match_nxt = 4'd0;
          end else begin
            w_state_nxt = LOCKED;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_match_nxt = 4'd0;
        end
      endcase
    end
  end

  // Lock FSM state, match count and status outputs
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEARCH; r_match <= 4'd0; r_locked <= 1'b0; r_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_match  <= w_match_nxt;
      r_locked <= (w_state_nxt == LOCKED);
      r_err    <= w_err_nxt;
    end
  end

  // Published geometry: loaded at frame start, dropped on loss of signal
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_total <= '0; r_h_active <= '0; r_v_total <= '0; r_v_active <= '0;
    end else if (w_timeout) begin
      r_h_total <= '0; r_h_active <= '0; r_v_total <= '0; r_v_active <= '0;
    end else if (w_geo_load) begin
      r_h_total <= w_h_last; r_h_active <= w_ha_last;
      r_v_total <= w_v_last; r_v_active <= w_va_last;
    end
  end

  assign pix_valid   = r_pix_valid;
  assign x           = r_x;
  assign y           = r_y;
  assign {pix_r, pix_g, pix_b} = r_pix_rgb;
  assign frame_start = r_frame_start;
  assign h_total     = r_h_total;
  assign h_active    = r_h_active;
  assign v_total     = r_v_total;
  assign v_active    = r_v_active;
  assign locked      = r_locked;
  assign err         = r_err;

`ifdef VIDEO_RX_CRC_EN
  logic [15:0] w_crc, r_frame_crc;
  logic        w_crc_clr, w_crc_pub, r_crc_valid;

  assign w_crc_clr = w_vs_rise | w_timeout | (r_state == SEARCH);
  assign w_crc_pub = w_vs_rise & ~w_timeout & (r_state != SEARCH);

  video_crc16 u_crc (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .i_clr     (w_crc_clr),
    .i_en      (r_de1),
    .i_data    (r_rgb1),
    .o_crc     (w_crc)
  );

  // Frame signature latch and strobe
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_crc <= 16'd0; r_crc_valid <= 1'b0;
    end else begin
      r_crc_valid <= w_crc_pub;
      if (w_crc_pub) r_frame_crc <= w_crc;
    end
  end

  assign frame_crc       = r_frame_crc;
  assign frame_crc_valid = r_crc_valid;
`endif

endmodule

// File: tb/tb_video_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for video_rx: toy timing 20x10 lines, 12x6 active.
module tb_video_rx;

  typedef struct {
    int          cyc;
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] rgb;
  } pix_t;

  logic pixel_clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   err_cnt = 0;
  pix_t pix_q[$];
  int   fs_q[$];

  always #5 pixel_clk = ~pixel_clk;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  video_rx_if vif();
  video_rx_if vif_n();

  assign vif_n.in_hsync = ~vif.in_hsync;
  assign vif_n.in_vsync = ~vif.in_vsync;
  assign vif_n.in_de    = vif.in_de;
  assign vif_n.in_r     = vif.in_r;
  assign vif_n.in_g     = vif.in_g;
  assign vif_n.in_b     = vif.in_b;

  logic        pix_valid, frame_start, locked, err;
  logic [15:0] x, y, h_total, h_active, v_total, v_active;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        pix_valid_n, frame_start_n, locked_n, err_n;
  logic [15:0] x_n, y_n, h_total_n, h_active_n, v_total_n, v_active_n;
  logic [3:0]  pix_r_n, pix_g_n, pix_b_n;

`ifdef VIDEO_RX_CRC_EN
  logic [15:0] frame_crc, frame_crc_n, crc_m;
  logic        frame_crc_valid, frame_crc_valid_n;
  logic [15:0] crc_q[$];
  bit          searching = 1'b1;

  function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] t;
    t = c;
    for (int i = 11; i >= 0; i--) t = (t[15] ^ d[i]) ? ((t << 1) ^ 16'h1021) : (t << 1);
    return t;
  endfunction
`endif

  video_rx dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .vin(vif.slave),
    .pix_valid(pix_valid), .x(x), .y(y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .locked(locked), .err(err)
`ifdef VIDEO_RX_CRC_EN
    , .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
`endif
  );

  video_rx #(.HSYNC_POL(0), .VSYNC_POL(0)) dut_n (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .vin(vif_n.slave),
    .pix_valid(pix_valid_n), .x(x_n), .y(y_n), .pix_r(pix_r_n), .pix_g(pix_g_n), .pix_b(pix_b_n),
    .frame_start(frame_start_n), .h_total(h_total_n), .h_active(h_active_n),
    .v_total(v_total_n), .v_active(v_active_n), .locked(locked_n), .err(err_n)
`ifdef VIDEO_RX_CRC_EN
    , .frame_crc(frame_crc_n), .frame_crc_valid(frame_crc_valid_n)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one clock of pins; queue what the DUT must show two clocks later.
  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input int ex, input int ey);
    pix_t e;
    @(negedge pixel_clk);
    if (vs && !vif.in_vsync) begin
      fs_q.push_back(cyc + 2);
`ifdef VIDEO_RX_CRC_EN
      if (!searching) crc_q.push_back(crc_m);
      searching = 1'b0;
      crc_m = 16'hFFFF;
`endif
    end
    vif.in_hsync = hs; vif.in_vsync = vs; vif.in_de = de;
    vif.in_r = r; vif.in_g = g; vif.in_b = b;
    if (de) begin
      e.cyc = cyc + 2; e.x = 16'(ex); e.y = 16'(ey); e.rgb = {r, g, b};
      pix_q.push_back(e);
`ifdef VIDEO_RX_CRC_EN
      crc_m = m_crc(crc_m, {r, g, b});
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 0, 0);
  endtask

  // 10 lines of 20 clocks (long_line gets 21); DE on lines 3..8, clocks 4..15
  task automatic drive_frame(input int long_line);
    for (int l = 0; l < 10; l++) begin
      for (int p = 0; p < ((l == long_line) ? 21 : 20); p++) begin
        drive(p < 2, l < 2, (l >= 3 && l <= 8 && p >= 4 && p <= 15),
              4'(p), 4'(l), 4'(p + l), p - 4, l - 3);
      end
    end
  endtask

  task automatic check_geom(input string tag);
    check({tag, " h_total"},  h_total,  64'd20);
    check({tag, " h_active"}, h_active, 64'd12);
    check({tag, " v_total"},  v_total,  64'd10);
    check({tag, " v_active"}, v_active, 64'd6);
  endtask

  // Scoreboard monitor: pixels, frame-start pulses, error pulses
  always @(negedge pixel_clk) begin
    if (reset_n) begin
      if (err) err_cnt++;
      if (pix_valid) begin
        if (pix_q.size() == 0) begin
          check("unexpected pix_valid", 64'd1, 64'd0);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pix latency", 64'(cyc), 64'(e.cyc));
          check("pix x/y/rgb", {x, y, pix_r, pix_g, pix_b}, {e.x, e.y, e.rgb});
        end
      end
      if (frame_start) begin
        if (fs_q.size() == 0) check("unexpected frame_start", 64'd1, 64'd0);
        else check("frame_start cycle", 64'(cyc), 64'(fs_q.pop_front()));
      end
`ifdef VIDEO_RX_CRC_EN
      if (frame_crc_valid) begin
        if (crc_q.size() == 0) check("unexpected frame_crc_valid", 64'd1, 64'd0);
        else check("frame_crc", frame_crc, crc_q.pop_front());
      end
`endif
    end
  end

  initial begin
`ifdef VIDEO_RX_CRC_EN
    crc_m = 16'hFFFF;
`endif
    reset_n = 1'b0;
    vif.in_hsync = 1'b0; vif.in_vsync = 1'b0; vif.in_de = 1'b0;
    vif.in_r = 4'd0; vif.in_g = 4'd0; vif.in_b = 4'd0;
    repeat (3) @(negedge pixel_clk);
    check("reset pix_valid", pix_valid, 64'd0);
    check("reset x", x, 64'd0);
    check("reset y", y, 64'd0);
    check("reset frame_start", frame_start, 64'd0);
    check("reset h_total", h_total, 64'd0);
    check("reset v_active", v_active, 64'd0);
    check("reset locked", locked, 64'd0);
    check("reset err", err, 64'd0);
    reset_n = 1'b1;
    idle(5);

    // frame starts 1..3: search exit, reference frame, first match
    repeat (3) drive_frame(-1);
    check("pre-lock locked", locked, 64'd0);
    check_geom("measure");
    drive_frame(-1);
    check("lock locked", locked, 64'd1);
    check("lock err count", 64'(err_cnt), 64'd0);
    check_geom("locked");

    // one 21-clock line while locked
    drive_frame(4);
    check("long line err count", 64'(err_cnt), 64'd1);
    check("long line locked", locked, 64'd0);
    drive_frame(-1);
    check("relock1 locked", locked, 64'd0);
    drive_frame(-1);
    check("relock2 locked", locked, 64'd1);

    // loss of signal
    idle(65600);
    check("timeout err count", 64'(err_cnt), 64'd2);
    check("timeout locked", locked, 64'd0);
`ifdef VIDEO_RX_CRC_EN
    searching = 1'b1;
`endif
    repeat (3) drive_frame(-1);
    check("post-timeout pre-lock", locked, 64'd0);
    drive_frame(-1);
    check("post-timeout locked", locked, 64'd1);
    check_geom("relocked");
    idle(20);

    check("pixel queue drained", 64'(pix_q.size()), 64'd0);
    check("frame_start queue drained", 64'(fs_q.size()), 64'd0);
    check("final err count", 64'(err_cnt), 64'd2);
    check("inv-pol locked", locked_n, 64'd1);
    check("inv-pol h_total", h_total_n, 64'd20);
    check("inv-pol h_active", h_active_n, 64'd12);
    check("inv-pol v_total", v_total_n, 64'd10);
    check("inv-pol v_active", v_active_n, 64'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
